// File: rtl/mem_uart_bus_if.sv
// CPU-side memory bus of mem_uart_bus.
//   address        : byte address (PC during fetch, data address otherwise)
//   write_data_mem : store byte
//   writeBack      : store strobe, one write per rising edge while high
//   read_data      : combinational read byte at address
interface mem_uart_bus_if;
  logic [31:0] address;
  logic [7:0]  write_data_mem;
  logic        writeBack;
  logic [7:0]  read_data;

  modport master (
    output address,
    output write_data_mem,
    output writeBack,
    input  read_data
  );

  modport slave (
    input  address,
    input  write_data_mem,
    input  writeBack,
    output read_data
  );
endinterface

// File: rtl/mem_uart_bus.sv
// Byte RAM plus a memory-mapped UART transmitter behind one CPU bus.
//   clk      : sole clock, rising edge
//   reset    : synchronous, active-low
//   bus      : mem_uart_bus_if.slave (address, write_data_mem, writeBack, read_data)
//   uart_tx  : serial line, idles high, 8N1 with CLKS_PER_BIT clocks per bit
//   tx_busy  : transmitter active or queue non-empty
// Address map: RAM at [0, RAM_DEPTH), TXDATA at 0xFFFFFFF0, STATUS at 0xFFFFFFF1.
// STATUS = {4'b0, overflow, queue_empty, queue_full, tx_busy}.
// Build option: define UART_FIFO_EN for a 4-entry transmit FIFO; otherwise a
// single holding register is used.
module mem_uart_bus #(
  parameter int unsigned RAM_DEPTH    = 1024,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_uart_bus_if.slave        bus,
  output logic                 uart_tx,
  output logic                 tx_busy
);

  localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int unsigned TMR_W  = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FFF1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Address decode
  logic              in_ram;
  logic              sel_tx;
  logic              sel_status;
  logic [RAM_AW-1:0] ram_idx;

  assign in_ram     = bus.address < 32'(RAM_DEPTH);
  assign sel_tx     = bus.address == TXDATA_ADDR;
  assign sel_status = bus.address == STATUS_ADDR;
  assign ram_idx    = bus.address[RAM_AW-1:0];

  // Queue handshake; a pop frees a slot in the same edge, so a push into a
  // full queue still succeeds when the FSM is popping.
  logic       q_push_req;
  logic       q_push;
  logic       q_pop;
  logic       q_empty;
  logic       q_full;
  logic       q_empty_d;
  logic [7:0] q_head;
  logic       ovf_set;
  logic       ovf_clr;
  logic       overflow_q;

  assign q_push_req = bus.writeBack & sel_tx;
  assign q_push     = q_push_req & (~q_full | q_pop);
  assign ovf_set    = q_push_req & q_full & ~q_pop;
  assign ovf_clr    = bus.writeBack & sel_status & bus.write_data_mem[3];

  // Data RAM, not reset
  logic [7:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (bus.writeBack && in_ram) begin
      mem[ram_idx] <= bus.write_data_mem;
    end
  end

  // Combinational read mux
  always_comb begin
    bus.read_data = 8'h00;
    if (in_ram) begin
      bus.read_data = mem[ram_idx];
    end else if (sel_status) begin
      bus.read_data = {4'b0000, overflow_q, q_empty, q_full, tx_busy};
    end
  end

  // Sticky overflow flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (ovf_set) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef UART_FIFO_EN
  // 4-entry FIFO; 2-bit pointers wrap modulo the depth on their own
  localparam int unsigned Q_DEPTH = 4;

  logic [7:0] fifo_mem [Q_DEPTH];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic [2:0] count_d;

  always_comb begin
    count_d = count_q;
    if (q_push && !q_pop) begin
      count_d = count_q + 3'd1;
    end else if (!q_push && q_pop) begin
      count_d = count_q - 3'd1;
    end
  end

  assign q_empty   = count_q == 3'd0;
  assign q_full    = count_q == 3'(Q_DEPTH);
  assign q_empty_d = count_d == 3'd0;
  assign q_head    = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (q_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (q_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) begin
      fifo_mem[wr_ptr_q] <= bus.write_data_mem;
    end
  end
`else
  // Single holding register, full whenever it holds a byte
  logic [7:0] hold_q;
  logic       hold_valid_q;
  logic       hold_valid_d;

  assign hold_valid_d = q_push | (hold_valid_q & ~q_pop);
  assign q_empty      = ~hold_valid_q;
  assign q_full       = hold_valid_q;
  assign q_empty_d    = ~hold_valid_d;
  assign q_head       = hold_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_valid_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) begin
      hold_q <= bus.write_data_mem;
    end
  end
`endif

  // Transmit FSM
  tx_state_e        state_q;
  tx_state_e        state_d;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic [2:0]       bit_idx_q;
  logic [2:0]       bit_idx_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             tx_d;
  logic             busy_d;
  logic             last_tick;

  assign last_tick = timer_q == TMR_W'(CLKS_PER_BIT - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      uart_tx   <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      uart_tx   <= tx_d;
      tx_busy   <= busy_d;
    end
  end

  // Next state; uart_tx is registered so each state's line level is set on
  // the edge that enters it. The shift register is shifted as bits go out,
  // so shift_q[0] is always the bit currently on the line.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = uart_tx;
    q_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!q_empty) begin
          q_pop   = 1'b1;
          shift_d = q_head;
          timer_d = '0;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (last_tick) begin
          timer_d   = '0;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_DATA: begin
        if (last_tick) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_STOP: begin
        if (last_tick) begin
          timer_d = '0;
          // Chain the next queued byte straight out of STOP
          if (!q_empty) begin
            q_pop   = 1'b1;
            shift_d = q_head;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || !q_empty_d;
  end

endmodule

// File: tb/tb_mem_uart_bus.sv
// Bench for mem_uart_bus with CLKS_PER_BIT=4, RAM_DEPTH=1024.
// Compile with UART_FIFO_EN defined to exercise the FIFO build.
module tb_mem_uart_bus;

  localparam int          C     = 4;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] TX_A  = 32'hFFFF_FFF0;
  localparam logic [31:0] ST_A  = 32'hFFFF_FFF1;

  logic clk = 1'b0;
  logic reset;
  logic uart_tx;
  logic tx_busy;

  mem_uart_bus_if bus ();

  mem_uart_bus #(
    .RAM_DEPTH    (DEPTH),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .uart_tx (uart_tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference RAM: only addresses in addr_q have known contents
  logic [7:0] ref_mem [DEPTH];
  logic [9:0] addr_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles after the start bit appears
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    logic [7:0] v;
    v = b;
    if (k < C) return 1'b0;
    if (k < 9 * C) return v[3'((k - C) / C)];
    return 1'b1;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.address        = a;
    bus.write_data_mem = d;
    bus.writeBack      = 1'b1;
    @(negedge clk);
    bus.writeBack      = 1'b0;
  endtask

  task automatic ram_wr(input logic [9:0] a, input logic [7:0] d);
    wr(32'(a), d);
    ref_mem[a] = d;
    addr_q.push_back(a);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [7:0] exp);
    bus.address = a;
    #1;
    chk(tag, 32'(bus.read_data), 32'(exp));
  endtask

  // n consecutive TXDATA writes of first, first+1, ...; returns at the
  // negedge after the last write edge
  task automatic burst(input logic [7:0] first, input int n);
    @(negedge clk);
    bus.address        = TX_A;
    bus.write_data_mem = first;
    bus.writeBack      = 1'b1;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      bus.write_data_mem = first + 8'(i);
    end
    @(negedge clk);
    bus.writeBack = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input int kstart);
    for (int k = kstart; k < 10 * C; k++) begin
      @(negedge clk);
      chk($sformatf("%s_k%0d", tag, k), 32'(uart_tx), 32'(exp_bit(b, k)));
    end
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(tx_busy), 32'h0);
    chk({tag, "_line"}, 32'(uart_tx), 32'h1);
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] a;

    reset              = 1'b0;
    bus.address        = 32'h0;
    bus.write_data_mem = 8'h00;
    bus.writeBack      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset state
    chk("rst_line", 32'(uart_tx), 32'h1);
    chk("rst_busy", 32'(tx_busy), 32'h0);
    rd_chk("rst_status", ST_A, 8'h04);

    // RAM directed
    ram_wr(10'h010, 8'hA5);
    rd_chk("ram_a5", 32'h10, 8'hA5);
    rd_chk("oor_400", 32'h400, 8'h00);
    rd_chk("txdata_rd", TX_A, 8'h00);
    rd_chk("other_rd", 32'hFFFF_FFF2, 8'h00);
    ram_wr(10'h000, 8'h5A);
    wr(32'h400, 8'h77);
    rd_chk("oor_wr_ignored", 32'h0, 8'h5A);
    rd_chk("status_after_ram", ST_A, 8'h04);

    // RAM random
    for (int i = 0; i < 40; i++) begin
      a = 10'($urandom_range(DEPTH - 1));
      ram_wr(a, 8'($urandom));
    end
    for (int i = 0; i < 40; i++) begin
      a = addr_q[$urandom_range(addr_q.size() - 1)];
      rd_chk($sformatf("ram_rand_%0h", a), 32'(a), ref_mem[a]);
    end

    // Single byte 0x55 from idle
    wr(TX_A, 8'h55);
    chk("lat_still_high", 32'(uart_tx), 32'h1);
    check_frame("tx55", 8'h55, 0);
    idle_chk("tx55_end");

    // Random single bytes
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      wr(TX_A, b);
      chk("rand_lat", 32'(uart_tx), 32'h1);
      check_frame($sformatf("rand%0d", i), b, 0);
      idle_chk("rand_end");
    end
    rd_chk("status_idle", ST_A, 8'h04);

`ifdef UART_FIFO_EN
    // Six back-to-back writes: 0x01 starts, 0x02..0x05 fill, 0x06 dropped
    burst(8'h01, 6);
    chk("fifo_k4", 32'(uart_tx), 32'(exp_bit(8'h01, 4)));
    rd_chk("fifo_ovf_status", ST_A, 8'h0B);
    check_frame("fifo01", 8'h01, 5);
    for (int i = 2; i <= 5; i++) begin
      check_frame($sformatf("fifo%0d", i), 8'(i), 0);
    end
    idle_chk("fifo_end");
    rd_chk("fifo_ovf_sticky", ST_A, 8'h0C);
    wr(ST_A, 8'hF7);
    rd_chk("fifo_ovf_keep", ST_A, 8'h0C);
    wr(ST_A, 8'h08);
    rd_chk("fifo_ovf_clr", ST_A, 8'h04);

    // Push on the edge that pops, with 4 entries held
    burst(8'h11, 5);
    rd_chk("full4_status", ST_A, 8'h03);
    check_frame("pp11", 8'h11, 4);
    bus.address        = TX_A;
    bus.write_data_mem = 8'h16;
    bus.writeBack      = 1'b1;
    @(negedge clk);
    bus.writeBack = 1'b0;
    chk("pp_k0", 32'(uart_tx), 32'h0);
    rd_chk("pp_status", ST_A, 8'h03);
    check_frame("pp12", 8'h12, 1);
    for (int i = 3; i <= 6; i++) begin
      check_frame($sformatf("pp1%0d", i), 8'h10 + 8'(i), 0);
    end
    idle_chk("pp_end");
    rd_chk("pp_final_status", ST_A, 8'h04);
`else
    // Two consecutive writes: second accepted as the first pops; third dropped
    burst(8'h3C, 2);
    chk("hold_k0", 32'(uart_tx), 32'h0);
    bus.address        = TX_A;
    bus.write_data_mem = 8'h99;
    bus.writeBack      = 1'b1;
    @(negedge clk);
    bus.writeBack = 1'b0;
    rd_chk("hold_ovf_status", ST_A, 8'h0B);
    check_frame("hold3c", 8'h3C, 2);
    check_frame("hold3d", 8'h3D, 0);
    idle_chk("hold_end");
    rd_chk("hold_ovf_sticky", ST_A, 8'h0C);
    wr(ST_A, 8'hF7);
    rd_chk("hold_ovf_keep", ST_A, 8'h0C);
    wr(ST_A, 8'h08);
    rd_chk("hold_ovf_clr", ST_A, 8'h04);
`endif

    // Reset in the middle of the data bits of 0xFF
    wr(TX_A, 8'hFF);
    repeat (3 * C) @(negedge clk);
    chk("mid_busy", 32'(tx_busy), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_line", 32'(uart_tx), 32'h1);
    chk("mid_rst_busy", 32'(tx_busy), 32'h0);
    reset = 1'b1;
    rd_chk("mid_rst_status", ST_A, 8'h04);
    repeat (2 * C) @(negedge clk);
    chk("post_rst_line", 32'(uart_tx), 32'h1);
    chk("post_rst_busy", 32'(tx_busy), 32'h0);
    foreach (addr_q[i]) begin
      rd_chk($sformatf("ram_keep_%0h", addr_q[i]), 32'(addr_q[i]), ref_mem[addr_q[i]]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_uart_bus.md
MEM_UART_BUS -- requirements
Module: mem_uart_bus

Interface
REQ-001 Parameter RAM_DEPTH, default 1024, SHALL set the data RAM size in bytes; RAM occupies addresses 0 .. RAM_DEPTH-1.
REQ-002 Parameter CLKS_PER_BIT, default 16, SHALL set the clock cycles per UART bit; legal values are 2 or more.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset: 0 sampled at a rising clk edge resets the block.
REQ-005 address  input  32  byte address from the CPU; carries the PC during instruction fetch and the data address otherwise.
REQ-006 write_data_mem  input  8  store byte from the CPU.
REQ-007 writeBack  input  1  store strobe; a write SHALL occur at each rising edge where it is 1.
REQ-008 read_data  output  8  byte at address; purely combinational, valid in the same cycle.
REQ-009 uart_tx  output  1  serial transmit line; idles at 1.
REQ-010 tx_busy  output  1  1 while the transmit FSM is not IDLE or the queue is non-empty.

Function
REQ-011 The address map SHALL be: RAM at address < RAM_DEPTH; TXDATA at 0xFFFFFFF0; STATUS at 0xFFFFFFF1; every other address reads 0x00 and ignores writes.
REQ-012 A RAM read SHALL be asynchronous: read_data = mem[address] with no latency, so the CPU can fetch both instruction bytes in consecutive cycles.
REQ-013 A RAM write SHALL update mem[address] at the edge where writeBack=1; the new value SHALL be visible on read_data from the next cycle.
REQ-014 The STATUS read value SHALL be {4'b0, overflow, queue_empty, queue_full, tx_busy} with bit0 = tx_busy.
REQ-015 A write to STATUS with data bit3=1 SHALL clear overflow; other bits of the write SHALL be ignored.
REQ-016 A read of TXDATA SHALL return 0x00, and reads SHALL have no side effects.
REQ-017 A write to TXDATA SHALL push write_data_mem into the transmit queue when the queue is not full.
REQ-018 A write to TXDATA while the queue is full SHALL be dropped and SHALL set the sticky overflow flag.
REQ-019 The transmit FSM SHALL have states IDLE, START, DATA and STOP, driven by a bit-timer counting 0 .. CLKS_PER_BIT-1 and a 3-bit bit index.
REQ-020 In IDLE with the queue non-empty at an edge, the FSM SHALL pop the head byte into the shift register, enter START and drive uart_tx=0.
REQ-021 START SHALL last CLKS_PER_BIT cycles, then the FSM SHALL enter DATA.
REQ-022 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, then the FSM SHALL enter STOP.
REQ-023 STOP SHALL drive uart_tx=1 for CLKS_PER_BIT cycles, then return to IDLE; a queued byte SHALL start at the edge leaving STOP, with no extra idle cycle.
REQ-024 A push and a pop at the same edge SHALL both take effect and leave the occupancy unchanged; a push to a full queue with a simultaneous pop SHALL succeed.
REQ-025 Latency: for a TXDATA write at edge N with the FSM IDLE and the queue empty, uart_tx SHALL go low after edge N+1.
REQ-026 Queue pointers SHALL wrap modulo the queue depth.
REQ-027 RAM addresses SHALL use only the low log2(RAM_DEPTH) bits after the range check.

Reset
REQ-028 While reset=0 at an edge, the block SHALL set FSM=IDLE, uart_tx=1, queue empty, overflow=0, bit-timer=0 and bit index=0.
REQ-029 Out of reset, tx_busy SHALL be 0 and STATUS SHALL read 0x04.
REQ-030 Reset asserted mid-frame SHALL abandon the frame, with uart_tx=1 from the reset edge.
REQ-031 RAM contents SHALL NOT be reset.

Configuration
REQ-032 With UART_FIFO_EN defined, the transmit queue SHALL be a 4-entry FIFO.
REQ-033 Without UART_FIFO_EN, the queue SHALL be a single holding register that is full whenever it holds a byte; all other behaviour is unchanged.

Verification (CLKS_PER_BIT=4, RAM_DEPTH=1024)
REQ-034 Write 0xA5 to RAM address 0x10 -> read_data=0xA5 with address=0x10 in the next cycle; address=0x400 reads 0x00.
REQ-035 Write 0x55 to TXDATA from idle -> uart_tx low from edge N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop=1 for 4 cycles, then tx_busy=0.
REQ-036 With UART_FIFO_EN defined, 6 back-to-back TXDATA writes 0x01..0x06 while byte 0x01 is already transmitting -> 0x01..0x05 are sent back to back and 0x06 is dropped; STATUS bit3=1 until a write of 0x08 to STATUS clears it.
REQ-037 Without UART_FIFO_EN, 2 TXDATA writes in consecutive cycles -> the first is sent; the second is dropped only if the holding register is still full, otherwise it is accepted.
REQ-038 Reset=0 for 1 cycle midway through the DATA bits of 0xFF -> uart_tx=1 from the reset edge, STATUS=0x04, and RAM contents are unchanged.
REQ-039 Push and pop at the same edge with the FIFO holding 4 entries -> occupancy stays 4 and overflow stays 0.
